// File: rtl/rv32_mem_pkg.sv
// Shared definitions for the RV32I data-memory path: access modes, arbiter states,
// owner ids and the registered transaction record.
package rv32_mem_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = XLEN / 8;

    localparam logic [2:0] MODE_B  = 3'b000;
    localparam logic [2:0] MODE_H  = 3'b001;
    localparam logic [2:0] MODE_W  = 3'b010;
    localparam logic [2:0] MODE_BU = 3'b100;
    localparam logic [2:0] MODE_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_LD  = 1'b1
    } owner_t;

    typedef struct packed {
        logic            we;
        logic [2:0]      mode;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        owner_t          owner;
    } txn_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane logic: store byte enables/replication, load extract/extend,
// and misalignment / invalid-mode detection.
module dmem_lane_align
    import rv32_mem_pkg::*;
(
    input  logic            i_we,
    input  logic [2:0]      i_mode,
    input  logic [1:0]      i_addr_lo,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [XLEN-1:0] i_mem_rdata,
    output logic [BE_W-1:0] o_be,
    output logic [XLEN-1:0] o_wdata,
    output logic [XLEN-1:0] o_rdata,
    output logic            o_err
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (i_addr_lo)
            2'd0:    w_byte = i_mem_rdata[7:0];
            2'd1:    w_byte = i_mem_rdata[15:8];
            2'd2:    w_byte = i_mem_rdata[23:16];
            default: w_byte = i_mem_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    end

    always_comb begin
        o_be    = 4'b1111;
        o_wdata = '0;
        o_rdata = '0;
        o_err   = 1'b0;
        case (i_mode)
            MODE_B: begin
                o_rdata = {{24{w_byte[7]}}, w_byte};
            end
            MODE_H: begin
                o_rdata = {{16{w_half[15]}}, w_half};
                o_err   = i_addr_lo[0];
            end
            MODE_W: begin
                o_rdata = i_mem_rdata;
                o_err   = |i_addr_lo;
            end
            MODE_BU: begin
                o_rdata = {24'h000000, w_byte};
                o_err   = i_we;
            end
            MODE_HU: begin
                o_rdata = {16'h0000, w_half};
                o_err   = i_we | i_addr_lo[0];
            end
            default: o_err = 1'b1;
        endcase
        // Store lane placement; loads keep all four enables.
        if (i_we) begin
            case (i_mode)
                MODE_B: begin
                    o_be    = 4'b0001 << i_addr_lo;
                    o_wdata = {4{i_wdata[7:0]}};
                end
                MODE_H: begin
                    o_be    = 4'b0011 << {i_addr_lo[1], 1'b0};
                    o_wdata = {2{i_wdata[15:0]}};
                end
                default: o_wdata = i_wdata;
            endcase
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and 3-cycle sequencer sharing one synchronous data memory
// between the CPU load/store port and the word-wide loader port.
module dmem_arbiter
    import rv32_mem_pkg::*;
#(
    parameter int unsigned MEM_AW = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [2:0]        cpu_mode,
    input  logic [XLEN-1:0]   cpu_addr,
    input  logic [XLEN-1:0]   cpu_wdata,
    output logic [XLEN-1:0]   cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_err,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [XLEN-1:0]   ld_addr,
    input  logic [XLEN-1:0]   ld_wdata,
    output logic [XLEN-1:0]   ld_rdata,
    output logic              ld_ack,
    output logic              ld_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [BE_W-1:0]   mem_be,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata
);

    state_t          r_state, w_next;
    owner_t          r_last_grant;
    txn_t            r_txn;
    logic            w_start, w_grant_ld, w_mem_en, w_err;
    logic [BE_W-1:0] w_be;
    logic [XLEN-1:0] w_wdata, w_rdata;
    logic            r_cpu_ack, r_cpu_err, r_ld_ack, r_ld_err;
    logic            w_unused;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next state and IDLE-only arbitration: on a tie, the side not granted last wins.
    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_grant_ld = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cpu_req || ld_req) begin
                    w_next     = ST_ACCESS;
                    w_start    = 1'b1;
                    w_grant_ld = ld_req && (!cpu_req || (r_last_grant == OWN_CPU));
                end
            end
            ST_ACCESS: w_next = ST_RESP;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_txn        <= '0;
            r_last_grant <= OWN_LD;
        end else if (w_start) begin
            r_last_grant <= w_grant_ld ? OWN_LD : OWN_CPU;
            if (w_grant_ld) begin
                r_txn.we    <= ld_we;
                r_txn.mode  <= MODE_W;
                r_txn.addr  <= ld_addr;
                r_txn.wdata <= ld_wdata;
                r_txn.owner <= OWN_LD;
            end else begin
                r_txn.we    <= cpu_we;
                r_txn.mode  <= cpu_mode;
                r_txn.addr  <= cpu_addr;
                r_txn.wdata <= cpu_wdata;
                r_txn.owner <= OWN_CPU;
            end
        end
    end

    dmem_lane_align u_align (
        .i_we        (r_txn.we),
        .i_mode      (r_txn.mode),
        .i_addr_lo   (r_txn.addr[1:0]),
        .i_wdata     (r_txn.wdata),
        .i_mem_rdata (mem_rdata),
        .o_be        (w_be),
        .o_wdata     (w_wdata),
        .o_rdata     (w_rdata),
        .o_err       (w_err)
    );

    // Completion flags are set on the ACCESS->RESP edge, so they live exactly in RESP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cpu_ack <= 1'b0;
            r_cpu_err <= 1'b0;
            r_ld_ack  <= 1'b0;
            r_ld_err  <= 1'b0;
        end else begin
            r_cpu_ack <= (r_state == ST_ACCESS) && (r_txn.owner == OWN_CPU);
            r_cpu_err <= (r_state == ST_ACCESS) && (r_txn.owner == OWN_CPU) && w_err;
            r_ld_ack  <= (r_state == ST_ACCESS) && (r_txn.owner == OWN_LD);
            r_ld_err  <= (r_state == ST_ACCESS) && (r_txn.owner == OWN_LD) && w_err;
        end
    end

    assign w_mem_en  = (r_state == ST_ACCESS) && !w_err;
    assign mem_en    = w_mem_en;
    assign mem_we    = w_mem_en && r_txn.we;
    assign mem_be    = w_mem_en ? w_be : '0;
    assign mem_addr  = w_mem_en ? r_txn.addr[MEM_AW+1:2] : '0;
    assign mem_wdata = w_mem_en ? w_wdata : '0;

    assign cpu_ack   = r_cpu_ack;
    assign cpu_err   = r_cpu_err;
    assign ld_ack    = r_ld_ack;
    assign ld_err    = r_ld_err;
    assign cpu_rdata = (r_cpu_ack && !r_cpu_err) ? w_rdata : '0;
    assign ld_rdata  = (r_ld_ack && !r_ld_err) ? w_rdata : '0;

    assign w_unused = &{1'b0, r_txn.addr[XLEN-1:MEM_AW+2]};

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the single-port synchronous data memory of the RV32I processor. It shares the memory between the CPU load/store path and a word-wide program/data loader port. It applies round-robin fairness, converts byte/half/word load-store modes into byte enables and sign/zero-extended read data, and flags misaligned accesses. The CPU uses `cpu_ack` to release its stall.

## Interface
Parameters:
- `MEM_AW`, default 10: word-address width of the attached memory (1024 words).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `cpu_req` in 1: CPU access request; held until `cpu_ack`.
- `cpu_we` in 1: 1 = store, 0 = load.
- `cpu_mode` in 3: funct3 encoding. 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- `cpu_addr` in 32: byte address.
- `cpu_wdata` in 32: store data, right-aligned.
- `cpu_rdata` out 32: extended load data; valid only while `cpu_ack`=1.
- `cpu_ack` out 1: one-cycle completion pulse.
- `cpu_err` out 1: completion with error; asserted together with `cpu_ack`.
- `ld_req` in 1: loader request. Loader is always word mode (010).
- `ld_we` in 1: loader write enable.
- `ld_addr` in 32: loader byte address.
- `ld_wdata` in 32: loader write data.
- `ld_rdata` out 32: loader read data; valid only while `ld_ack`=1.
- `ld_ack` out 1: loader completion pulse.
- `ld_err` out 1: loader completion with error.
- `mem_en` out 1: memory cycle enable.
- `mem_we` out 1: memory write enable.
- `mem_be` out 4: byte enables; bit i selects bits 8i+7:8i.
- `mem_addr` out MEM_AW: word address, `addr[MEM_AW+1:2]`. Upper bits are truncated, so addresses wrap.
- `mem_wdata` out 32: lane-replicated write data.
- `mem_rdata` in 32: memory read data, valid in the cycle after `mem_en`.

## Operation
- FSM states are IDLE, ACCESS and RESP. Transitions: IDLE→ACCESS when any req is high; ACCESS→RESP always; RESP→IDLE always.
- Arbitration happens in IDLE only.
  - If one requester is active, it wins.
  - If both are active, the winner is the one not granted last (`last_grant` flag).
  - `last_grant` resets to LOADER, so the CPU wins the first tie.
- On the IDLE→ACCESS edge, the winner's we/mode/addr/wdata and owner id are registered. Later changes on the requester's inputs have no effect on the transaction in flight.
- Error check at grant time:
  - Invalid mode (011, 110, 111).
  - Half access with `addr[0]`=1.
  - Word access with `addr[1:0]`≠00.
  - Store with mode 100 or 101.
- When an access is in error, no memory cycle occurs in ACCESS (`mem_en`=0). In RESP the owner gets ack=1, err=1 and rdata=0.
- Store lanes:
  - SB: `mem_be` = 0001<<addr[1:0]; wdata byte replicated ×4.
  - SH: `mem_be` = 0011<<{addr[1],1'b0}; halfword replicated ×2.
  - SW: `mem_be` = 1111.
- Loads drive `mem_be`=1111 and `mem_we`=0.
- Load extraction in RESP uses the registered addr[1:0] and mode to select the lane. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- The non-owner's ack/err are 0, and its rdata is 0.

## Timing
- Reset (asynchronous, any state) forces the following:
  - state=IDLE and `last_grant`=LOADER.
  - All outputs are 0: mem_*, acks, errs, rdata.
  - A transaction in flight is dropped with no ack.
- Latency for a request first seen high in IDLE cycle C0:
  - C1 (ACCESS): mem_en, mem_we, mem_be, mem_addr and mem_wdata are driven from registers.
  - C2 (RESP): ack pulse; rdata is derived combinationally from `mem_rdata`.
  - C3 (IDLE): arbitration resumes.
- Throughput is one access per 3 cycles.
- A requester must lower req in C3 or present its next request there. A req still high in C3 is treated as a new request.
- mem_* outputs are nonzero only in ACCESS.
- Simultaneous requests: the loser stays pending and is granted at the next IDLE, so wait is at most 3 cycles.
- A requester dropping req after grant is illegal. The transaction still completes and acks.

## Structure
- A shared package/header `rv32_mem_pkg` holds:
  - mode constants (MODE_B, MODE_H, MODE_W, MODE_BU, MODE_HU);
  - FSM state encoding;
  - owner ids (OWN_CPU, OWN_LD).
- Sub-module `dmem_lane_align` is purely combinational. It computes the store be/wdata, the load extract/extend, and the misalign/invalid error. It is instantiated once and driven from the registered transaction fields.

## Test plan
- CPU SW at 0x10 with data 0xDEADBEEF, then LW 0x10:
  - SW: C1 drives mem_addr=4, be=1111, we=1; C2 cpu_ack=1.
  - LW: ack in C2 with rdata=0xDEADBEEF.
- Memory word 0x80F0_7F01 at 0x20, then LB 0x20, LB 0x23, LBU 0x23 and LH 0x22:
  - LB 0x20 → 0x00000001.
  - LB 0x23 → 0xFFFFFF80.
  - LBU 0x23 → 0x00000080.
  - LH 0x22 → 0xFFFF80F0.
- SB 0x31 with data 0x000000AB → be=0010, mem_wdata=0xABABABAB. SH 0x32 → be=1100.
- Misaligned LW 0x42 and SH 0x43 → mem_en stays 0; ack=1, err=1 and rdata=0 in C2.
- Both req high continuously for 12 cycles → grants alternate CPU, LD, CPU, LD, with an ack every 3 cycles. A reset pulse in ACCESS clears everything: no ack, and the next tie goes to the CPU.
